// File: rtl/snn_noc_pkg.sv
// Shared NoC definitions for the SNN fabric.
// Holds the packet type and endpoint FSM encodings, the packet field offsets
// (derived from packet width and address width), and a packet builder for
// the default 35-bit packet.
package snn_noc_pkg;

  localparam int unsigned PKT_W      = 35;
  localparam int unsigned NOC_ADDR_W = 4;
  localparam int unsigned TYPE_W     = 2;
  localparam int unsigned PAYLOAD_W  = PKT_W - 2 * NOC_ADDR_W - TYPE_W;

  typedef enum logic [1:0] {
    PKT_CTRL_CLR = 2'b00,
    PKT_RES_RD   = 2'b01,
    PKT_RES_WR   = 2'b10,
    PKT_SPIKE_WR = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic int unsigned dest_lsb(int unsigned w, int unsigned a);
    return w - a;
  endfunction

  function automatic int unsigned src_lsb(int unsigned w, int unsigned a);
    return w - 2 * a;
  endfunction

  function automatic int unsigned type_lsb(int unsigned w, int unsigned a);
    return w - 2 * a - TYPE_W;
  endfunction

  function automatic logic [PKT_W-1:0] make_pkt(
    logic [NOC_ADDR_W-1:0] dest,
    logic [NOC_ADDR_W-1:0] src,
    pkt_type_e             ptype,
    logic [PAYLOAD_W-1:0]  payload
  );
    return {dest, src, ptype, payload};
  endfunction

endpackage

// File: rtl/ofm_res_node_if.sv
// Router <-> node packet link.
// in_*  : router -> node packets (valid/ready).
// out_* : node -> router packets (valid/ready).
// master: router side; slave: node side.
interface ofm_res_node_if #(
  parameter int unsigned WIDTH = 35
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ofm_res_node_pkt_dec.sv
// ofm_pkt_dec: combinational field extractor for incoming packets.
// Inputs : pkt (raw packet).
// Outputs: src, ptype, row, col, value fields; err_addr (dest != MY_ADDR);
//          err_range (row >= ROWS or col >= COLS).
module ofm_pkt_dec
  import snn_noc_pkg::*;
#(
  parameter int unsigned       WIDTH   = 35,
  parameter int unsigned       ADDR_W  = 4,
  parameter int unsigned       ROWS    = 28,
  parameter int unsigned       COLS    = 28,
  parameter int unsigned       RES_W   = 8,
  parameter int unsigned       ROW_W   = $clog2(ROWS),
  parameter int unsigned       COL_W   = $clog2(COLS),
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'b1100
) (
  input  logic [WIDTH-1:0]  pkt,
  output logic [ADDR_W-1:0] src,
  output pkt_type_e         ptype,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [RES_W-1:0]  value,
  output logic              err_addr,
  output logic              err_range
);
  localparam int unsigned DEST_LSB = dest_lsb(WIDTH, ADDR_W);
  localparam int unsigned SRC_LSB  = src_lsb(WIDTH, ADDR_W);
  localparam int unsigned TYPE_LSB = type_lsb(WIDTH, ADDR_W);
  localparam int unsigned ROW_LSB  = TYPE_LSB - ROW_W;
  localparam int unsigned COL_LSB  = ROW_LSB - COL_W;
  localparam int unsigned PAD_W    = COL_LSB - RES_W;
  localparam logic [ROW_W:0] ROWS_L = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0] COLS_L = (COL_W + 1)'(COLS);

  assign src   = pkt[SRC_LSB +: ADDR_W];
  assign ptype = pkt_type_e'(pkt[TYPE_LSB +: TYPE_W]);
  assign row   = pkt[ROW_LSB +: ROW_W];
  assign col   = pkt[COL_LSB +: COL_W];
  assign value = pkt[RES_W-1:0];

  assign err_addr  = (pkt[DEST_LSB +: ADDR_W] != MY_ADDR);
  assign err_range = ({1'b0, row} >= ROWS_L) || ({1'b0, col} >= COLS_L);

  // Padding between col and value carries no information.
  if (PAD_W > 0) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^pkt[RES_W +: PAD_W];
  end
endmodule

// File: rtl/ofm_res_node.sv
// ofm_res_node: NoC endpoint holding the output spike map and residuals.
// Ports: clk, reset (sync, active-high); bus (slave side of the router
// link: in_data/in_valid/in_ready, out_data/out_valid/out_ready);
// err (one-cycle pulse after accepting a bad packet); busy (RESP or CLEAR).
module ofm_res_node
  import snn_noc_pkg::*;
#(
  parameter int unsigned       WIDTH   = 35,
  parameter int unsigned       ADDR_W  = 4,
  parameter int unsigned       ROWS    = 28,
  parameter int unsigned       COLS    = 28,
  parameter int unsigned       RES_W   = 8,
  parameter int unsigned       CNT_W   = 16,
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'b1100
) (
  input  logic           clk,
  input  logic           reset,
  ofm_res_node_if.slave  bus,
  output logic           err,
  output logic           busy
);
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned DEST_LSB = dest_lsb(WIDTH, ADDR_W);
  localparam int unsigned SRC_LSB  = src_lsb(WIDTH, ADDR_W);
  localparam int unsigned TYPE_LSB = type_lsb(WIDTH, ADDR_W);
  localparam int unsigned ROW_LSB  = TYPE_LSB - ROW_W;
  localparam int unsigned COL_LSB  = ROW_LSB - COL_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  if (WIDTH < 2 * ADDR_W + TYPE_W + ROW_W + COL_W + RES_W) begin : g_chk_fields
    $error("ofm_res_node: WIDTH too small for packet fields");
  end
  if (WIDTH < 2 * ADDR_W + TYPE_W + CNT_W) begin : g_chk_cnt
    $error("ofm_res_node: WIDTH too small for spike count ack");
  end

  logic [ADDR_W-1:0] dec_src;
  pkt_type_e         dec_type;
  logic [ROW_W-1:0]  dec_row;
  logic [COL_W-1:0]  dec_col;
  logic [RES_W-1:0]  dec_value;
  logic              err_addr;
  logic              err_range;

  ofm_pkt_dec #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .ROWS    (ROWS),
    .COLS    (COLS),
    .RES_W   (RES_W),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W),
    .MY_ADDR (MY_ADDR)
  ) u_dec (
    .pkt       (bus.in_data),
    .src       (dec_src),
    .ptype     (dec_type),
    .row       (dec_row),
    .col       (dec_col),
    .value     (dec_value),
    .err_addr  (err_addr),
    .err_range (err_range)
  );

  state_e                                   state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]                spike_q, spike_d;
  logic [ROWS-1:0][COLS-1:0][RES_W-1:0]     res_q, res_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;
  logic [ROW_W-1:0]                         row_ctr_q, row_ctr_d;
  logic [ADDR_W-1:0]                        src_q, src_d;
  logic [WIDTH-1:0]                         out_data_q, out_data_d;
  logic                                     out_valid_q, out_valid_d;
  logic                                     err_q, err_d;
  logic                                     ack_pend_q, ack_pend_d;

  logic             in_ready_w;
  logic             accept;
  logic [WIDTH-1:0] reply;
  logic [WIDTH-1:0] ack;

  assign in_ready_w = ~reset & (state_q == ST_IDLE);
  assign accept     = bus.in_valid & in_ready_w;

  always_comb begin
    reply = '0;
    reply[DEST_LSB +: ADDR_W] = dec_src;
    reply[SRC_LSB +: ADDR_W]  = MY_ADDR;
    reply[TYPE_LSB +: TYPE_W] = PKT_RES_WR;
    reply[ROW_LSB +: ROW_W]   = dec_row;
    reply[COL_LSB +: COL_W]   = dec_col;
    reply[RES_W-1:0]          = err_range ? '0 : res_q[dec_row][dec_col];

    ack = '0;
    ack[DEST_LSB +: ADDR_W] = src_q;
    ack[SRC_LSB +: ADDR_W]  = MY_ADDR;
    ack[TYPE_LSB +: TYPE_W] = PKT_CTRL_CLR;
    ack[CNT_W-1:0]          = cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    spike_d     = spike_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    row_ctr_d   = row_ctr_q;
    src_d       = src_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_pend_d  = ack_pend_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = err_addr | (err_range & (dec_type != PKT_CTRL_CLR));
          if (!err_addr) begin
            case (dec_type)
              PKT_SPIKE_WR: begin
                // Only a 0->1 transition counts, so duplicates are free.
                if (!err_range && !spike_q[dec_row][dec_col]) begin
                  spike_d[dec_row][dec_col] = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
              end
              PKT_RES_WR: begin
                if (!err_range) res_d[dec_row][dec_col] = dec_value;
              end
              PKT_RES_RD: begin
                out_data_d  = reply;
                out_valid_d = 1'b1;
                ack_pend_d  = 1'b0;
                state_d     = ST_RESP;
              end
              PKT_CTRL_CLR: begin
                src_d     = dec_src;
                row_ctr_d = '0;
                state_d   = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        spike_d[row_ctr_q] = '0;
        row_ctr_d          = row_ctr_q + 1'b1;
        if (row_ctr_q == LAST_ROW) begin
          row_ctr_d   = '0;
          out_data_d  = ack;
          out_valid_d = 1'b1;
          ack_pend_d  = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          ack_pend_d  = 1'b0;
          state_d     = ST_IDLE;
          // The count belongs to the timestep just acknowledged.
          if (ack_pend_q) cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      spike_q     <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      row_ctr_q   <= '0;
      src_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ack_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      spike_q     <= spike_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      row_ctr_q   <= row_ctr_d;
      src_q       <= src_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      ack_pend_q  <= ack_pend_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = ~reset & out_valid_q;
  assign bus.out_data  = reset ? '0 : out_data_q;
  assign err           = ~reset & err_q;
  assign busy          = ~reset & (state_q != ST_IDLE);
endmodule

// File: tb/tb_ofm_res_node.sv
module tb_ofm_res_node;
  import snn_noc_pkg::*;

  localparam logic [3:0] MY = 4'b1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;          // 0: default instance, 1: 4x4 / RES_W=12 instance
  logic [34:0] tin_data;
  logic        tin_valid;
  logic        tout_ready;

  ofm_res_node_if #(.WIDTH(35)) bus ();
  ofm_res_node_if #(.WIDTH(35)) bus_s ();

  assign bus.in_data    = tin_data;
  assign bus.in_valid   = tin_valid & ~sel;
  assign bus.out_ready  = tout_ready & ~sel;
  assign bus_s.in_data  = tin_data;
  assign bus_s.in_valid = tin_valid & sel;
  assign bus_s.out_ready = tout_ready & sel;

  logic err_l, busy_l, err_s, busy_s;

  ofm_res_node #(.WIDTH(35), .ADDR_W(4), .ROWS(28), .COLS(28), .RES_W(8),
                 .CNT_W(16), .MY_ADDR(MY)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err(err_l), .busy(busy_l));

  ofm_res_node #(.ROWS(4), .COLS(4), .RES_W(12)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s), .err(err_s), .busy(busy_s));

  logic [34:0] o_data;
  logic        o_valid, o_in_ready, o_err, o_busy;
  assign o_data     = sel ? bus_s.out_data  : bus.out_data;
  assign o_valid    = sel ? bus_s.out_valid : bus.out_valid;
  assign o_in_ready = sel ? bus_s.in_ready  : bus.in_ready;
  assign o_err      = sel ? err_s : err_l;
  assign o_busy     = sel ? busy_s : busy_l;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload layouts: 28x28/8-bit node and 4x4/12-bit node.
  function automatic logic [24:0] pl(int unsigned r, int unsigned c, int unsigned v);
    return 25'((r << 20) | (c << 15) | v);
  endfunction
  function automatic logic [24:0] pls(int unsigned r, int unsigned c, int unsigned v);
    return 25'((r << 23) | (c << 21) | v);
  endfunction

  // ---------------- reference model (28x28 node) ----------------
  bit          m_spike [28][28];
  int unsigned m_res   [28][28];
  int unsigned m_cnt;

  task automatic model_reset();
    foreach (m_spike[i, j]) begin
      m_spike[i][j] = 1'b0;
      m_res[i][j]   = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [34:0] pkt, output bit e_err, output bit e_valid,
                            output logic [34:0] e_data, output int e_clr);
    int unsigned d, s, t, r, c, v;
    bit inr;
    d = pkt[34:31]; s = pkt[30:27]; t = pkt[26:25];
    r = pkt[24:20]; c = pkt[19:15]; v = pkt[7:0];
    inr = (r < 28) && (c < 28);
    e_err = 0; e_valid = 0; e_data = '0; e_clr = 0;
    if (d != MY) begin
      e_err = 1;
      return;
    end
    case (t)
      3: begin
        e_err = !inr;
        if (inr && !m_spike[r][c]) begin
          m_spike[r][c] = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      2: begin
        e_err = !inr;
        if (inr) m_res[r][c] = v;
      end
      1: begin
        e_err   = !inr;
        e_valid = 1;
        e_data  = make_pkt(4'(s), MY, PKT_RES_WR, pl(r, c, inr ? m_res[r][c] : 0));
      end
      default: begin
        e_valid = 1;
        e_clr   = 28;
        e_data  = make_pkt(4'(s), MY, PKT_CTRL_CLR, 25'(m_cnt));
        foreach (m_spike[i, j]) m_spike[i][j] = 1'b0;
        m_cnt = 0;
      end
    endcase
  endtask

  // Send one packet, observe err/response, drain the response with `delay`
  // cycles of back-pressure. g_clr counts cycles spent busy before out_valid.
  task automatic xact(input logic [34:0] pkt, input int delay, output bit g_err,
                      output bit g_valid, output logic [34:0] g_data, output int g_clr);
    int n;
    n = 0;
    while (!o_in_ready && n < 200) begin n++; tick(); end
    chk("accept_ready", o_in_ready, 1);
    tin_data = pkt; tin_valid = 1'b1;
    tick();
    tin_valid = 1'b0;
    g_err = o_err;
    n = 0;
    while (o_busy && !o_valid && n < 200) begin n++; tick(); end
    g_clr   = n;
    g_valid = o_valid;
    g_data  = '0;
    if (g_valid) begin
      g_data = o_data;
      chk("resp_in_ready", o_in_ready, 0);
      for (int k = 0; k < delay; k++) begin
        tick();
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, g_data);
        chk("hold_in_ready", o_in_ready, 0);
      end
      tout_ready = 1'b1;
      tick();
      tout_ready = 1'b0;
      chk("valid_drop", o_valid, 0);
      chk("busy_drop", o_busy, 0);
    end else begin
      tick();
    end
    chk("err_pulse_end", o_err, 0);
  endtask

  typedef struct {
    logic [34:0] pkt;
    bit          e_err;
    bit          e_valid;
    logic [34:0] e_data;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit g_err, g_valid, e_err, e_valid;
    logic [34:0] g_data, e_data;
    int g_clr, e_clr, seen;
    int unsigned pr [10];
    int unsigned pc [10];

    tbl[0]  = '{make_pkt(MY, 4'd1, PKT_RES_WR, pl(3, 5, 8'h5A)), 0, 0, '0};
    tbl[1]  = '{make_pkt(MY, 4'd1, PKT_RES_RD, pl(3, 5, 0)), 0, 1,
                make_pkt(4'd1, MY, PKT_RES_WR, pl(3, 5, 8'h5A))};
    tbl[2]  = '{make_pkt(4'b0011, 4'd1, PKT_RES_WR, pl(3, 5, 8'h11)), 1, 0, '0};
    tbl[3]  = '{make_pkt(MY, 4'd2, PKT_RES_RD, pl(3, 5, 0)), 0, 1,
                make_pkt(4'd2, MY, PKT_RES_WR, pl(3, 5, 8'h5A))};
    tbl[4]  = '{make_pkt(MY, 4'd4, PKT_RES_RD, pl(28, 0, 0)), 1, 1,
                make_pkt(4'd4, MY, PKT_RES_WR, pl(28, 0, 0))};
    tbl[5]  = '{make_pkt(MY, 4'd4, PKT_RES_WR, pl(2, 30, 8'h77)), 1, 0, '0};
    tbl[6]  = '{make_pkt(MY, 4'd5, PKT_RES_RD, pl(27, 27, 0)), 0, 1,
                make_pkt(4'd5, MY, PKT_RES_WR, pl(27, 27, 0))};
    tbl[7]  = '{make_pkt(MY, 4'd5, PKT_RES_WR, pl(27, 27, 8'hFF)), 0, 0, '0};
    tbl[8]  = '{make_pkt(MY, 4'd6, PKT_RES_RD, pl(27, 27, 0)), 0, 1,
                make_pkt(4'd6, MY, PKT_RES_WR, pl(27, 27, 8'hFF))};
    tbl[9]  = '{make_pkt(4'b0011, 4'd6, PKT_SPIKE_WR, pl(1, 1, 0)), 1, 0, '0};
    tbl[10] = '{make_pkt(MY, 4'hF, PKT_RES_RD, pl(0, 0, 0)), 0, 1,
                make_pkt(4'hF, MY, PKT_RES_WR, pl(0, 0, 0))};

    pr = '{0, 0, 27, 27, 13, 5, 1, 20, 9, 14};
    pc = '{0, 27, 0, 27, 14, 5, 2, 3, 9, 26};

    reset = 1'b1; sel = 1'b0; tin_data = '0; tin_valid = 1'b0; tout_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_valid, 0);
    chk("rst_out_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", o_in_ready, 1);

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 11; i++) begin
      xact(tbl[i].pkt, 0, g_err, g_valid, g_data, g_clr);
      model_step(tbl[i].pkt, e_err, e_valid, e_data, e_clr);
      chk($sformatf("vec%0d_err", i), g_err, tbl[i].e_err);
      chk($sformatf("vec%0d_valid", i), g_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_data", i), g_data, tbl[i].e_data);
        chk($sformatf("vec%0d_latency", i), g_clr, 0);
      end
    end

    // ---- spike counting + clear sweep, twice ----
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 11; i++) begin
        logic [34:0] p;
        p = make_pkt(MY, 4'd3, PKT_SPIKE_WR, pl(pr[i % 10], pc[i % 10], 0));
        if (i == 10) p = make_pkt(MY, 4'd3, PKT_SPIKE_WR, pl(5, 5, 0));
        xact(p, 0, g_err, g_valid, g_data, g_clr);
        model_step(p, e_err, e_valid, e_data, e_clr);
        chk("spike_err", g_err, 0);
        chk("spike_valid", g_valid, 0);
      end
      xact(make_pkt(MY, 4'b0111, PKT_CTRL_CLR, '0), 1, g_err, g_valid, g_data, g_clr);
      model_step(make_pkt(MY, 4'b0111, PKT_CTRL_CLR, '0), e_err, e_valid, e_data, e_clr);
      chk("clr_cycles", g_clr, 28);
      chk("clr_valid", g_valid, 1);
      chk("clr_ack", g_data, make_pkt(4'b0111, MY, PKT_CTRL_CLR, 25'd10));
      chk("clr_err", g_err, 0);
    end
    xact(make_pkt(MY, 4'd1, PKT_RES_RD, pl(3, 5, 0)), 0, g_err, g_valid, g_data, g_clr);
    chk("res_kept_35", g_data, make_pkt(4'd1, MY, PKT_RES_WR, pl(3, 5, 8'h5A)));
    xact(make_pkt(MY, 4'd1, PKT_RES_RD, pl(27, 27, 0)), 0, g_err, g_valid, g_data, g_clr);
    chk("res_kept_2727", g_data, make_pkt(4'd1, MY, PKT_RES_WR, pl(27, 27, 8'hFF)));

    // ---- back-pressure: out_ready low 5 cycles ----
    xact(make_pkt(MY, 4'd1, PKT_RES_RD, pl(3, 5, 0)), 5, g_err, g_valid, g_data, g_clr);
    chk("bp_data", g_data, make_pkt(4'd1, MY, PKT_RES_WR, pl(3, 5, 8'h5A)));

    // ---- randomized traffic against the model ----
    for (int it = 0; it < 300; it++) begin
      int unsigned t, d, r, c, v, pad;
      logic [34:0] p;
      t = $urandom_range(0, 3);
      if (t == 0 && $urandom_range(0, 3) != 0) t = 3;
      d = MY;
      if ($urandom_range(0, 9) == 0) begin
        d = $urandom_range(0, 15);
        if (d == MY) d = 0;
      end
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 3); c = $urandom_range(0, 3);
      end else begin
        r = $urandom_range(0, 31); c = $urandom_range(0, 31);
      end
      v = $urandom_range(0, 255);
      pad = $urandom_range(0, 127);
      p = make_pkt(4'(d), 4'($urandom_range(0, 15)), pkt_type_e'(t), pl(r, c, v) | 25'(pad << 8));
      xact(p, int'($urandom_range(0, 3)), g_err, g_valid, g_data, g_clr);
      model_step(p, e_err, e_valid, e_data, e_clr);
      chk($sformatf("rnd%0d_err", it), g_err, e_err);
      chk($sformatf("rnd%0d_valid", it), g_valid, e_valid);
      if (e_valid) begin
        chk($sformatf("rnd%0d_data", it), g_data, e_data);
        chk($sformatf("rnd%0d_cycles", it), g_clr, e_clr);
      end
    end

    // ---- reset in the middle of a clear ----
    xact(make_pkt(MY, 4'd1, PKT_RES_WR, pl(3, 5, 8'h5A)), 0, g_err, g_valid, g_data, g_clr);
    xact(make_pkt(MY, 4'd1, PKT_SPIKE_WR, pl(4, 4, 0)), 0, g_err, g_valid, g_data, g_clr);
    tin_data = make_pkt(MY, 4'b0111, PKT_CTRL_CLR, '0); tin_valid = 1'b1;
    tick();
    tin_valid = 1'b0;
    repeat (10) tick();
    chk("mid_clr_busy", o_busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_hi_busy", o_busy, 0);
    chk("rst_hi_valid", o_valid, 0);
    chk("rst_hi_in_ready", o_in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    chk("after_rst_in_ready", o_in_ready, 1);
    chk("after_rst_busy", o_busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_valid) seen++;
    end
    chk("no_ack_after_rst", seen, 0);
    xact(make_pkt(MY, 4'd1, PKT_RES_RD, pl(3, 5, 0)), 0, g_err, g_valid, g_data, g_clr);
    chk("res_zeroed", g_data, make_pkt(4'd1, MY, PKT_RES_WR, pl(3, 5, 0)));
    xact(make_pkt(MY, 4'd2, PKT_CTRL_CLR, '0), 0, g_err, g_valid, g_data, g_clr);
    chk("cnt_zeroed", g_data, make_pkt(4'd2, MY, PKT_CTRL_CLR, 25'd0));
    chk("cnt_zeroed_cycles", g_clr, 28);

    // ---- 4x4, 12-bit residual instance ----
    sel = 1'b1;
    #1;
    xact(make_pkt(MY, 4'd2, PKT_RES_WR, pls(3, 3, 12'hFFF)), 0, g_err, g_valid, g_data, g_clr);
    chk("s_wr_err", g_err, 0);
    chk("s_wr_valid", g_valid, 0);
    xact(make_pkt(MY, 4'd2, PKT_RES_RD, pls(3, 3, 0)), 2, g_err, g_valid, g_data, g_clr);
    chk("s_rd_data", g_data, make_pkt(4'd2, MY, PKT_RES_WR, pls(3, 3, 12'hFFF)));
    chk("s_rd_latency", g_clr, 0);
    xact(make_pkt(MY, 4'd2, PKT_RES_RD, pls(0, 0, 0)), 0, g_err, g_valid, g_data, g_clr);
    chk("s_rd_zero", g_data, make_pkt(4'd2, MY, PKT_RES_WR, pls(0, 0, 0)));
    xact(make_pkt(MY, 4'd2, PKT_SPIKE_WR, pls(3, 3, 0)), 0, g_err, g_valid, g_data, g_clr);
    xact(make_pkt(MY, 4'd2, PKT_SPIKE_WR, pls(0, 0, 0)), 0, g_err, g_valid, g_data, g_clr);
    xact(make_pkt(MY, 4'd2, PKT_SPIKE_WR, pls(3, 3, 0)), 0, g_err, g_valid, g_data, g_clr);
    xact(make_pkt(MY, 4'd9, PKT_CTRL_CLR, '0), 0, g_err, g_valid, g_data, g_clr);
    chk("s_clr_cycles", g_clr, 4);
    chk("s_clr_ack", g_data, make_pkt(4'd9, MY, PKT_CTRL_CLR, 25'd2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
